// File: rtl/vga2_pkg.sv
// -----------------------------------------------------------------------------
// vga2_pkg
// Shared types and helpers for the VGA2 framebuffer block.
//   color_t      : packed (r,g,b) colour triple, one bit per channel
//   state_t      : framebuffer control states (IDLE, CLEAR)
//   COLOR_BLACK  : all-channels-off colour
//   lin_index()  : linear pixel index v*width + h
// -----------------------------------------------------------------------------
package vga2_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } color_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam color_t COLOR_BLACK = '{r: 1'b0, g: 1'b0, b: 1'b0};

  // Computed at 64 bits so callers can cast down to HAddrSize+VAddrSize bits
  // without any intermediate product being clipped.
  function automatic logic [63:0] lin_index(input logic [63:0] h,
                                            input logic [63:0] v,
                                            input logic [63:0] width);
    return (v * width) + h;
  endfunction

endpackage

// File: rtl/vga2_framebuffer_if.sv
// -----------------------------------------------------------------------------
// vga2_framebuffer_if
// Drawing-client bus of the framebuffer: pixel write handshake plus the
// clear-engine controls.
//   wr_valid/wr_ready        : write handshake (client -> framebuffer)
//   wr_h, wr_v               : write column / line
//   wr_r, wr_g, wr_b         : write colour
//   clr_start                : one-cycle pulse, start a whole-buffer fill
//   clr_r, clr_g, clr_b      : fill colour, sampled with clr_start
//   busy                     : fill in progress
// modport master : drawing client
// modport slave  : framebuffer
// -----------------------------------------------------------------------------
interface vga2_framebuffer_if #(
  parameter int HAddrSize = 11,
  parameter int VAddrSize = 11
);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [HAddrSize-1:0] wr_h;
  logic [VAddrSize-1:0] wr_v;
  logic                 wr_r;
  logic                 wr_g;
  logic                 wr_b;
  logic                 clr_start;
  logic                 clr_r;
  logic                 clr_g;
  logic                 clr_b;
  logic                 busy;

  modport master (
    output wr_valid, wr_h, wr_v, wr_r, wr_g, wr_b,
    output clr_start, clr_r, clr_g, clr_b,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_valid, wr_h, wr_v, wr_r, wr_g, wr_b,
    input  clr_start, clr_r, clr_g, clr_b,
    output wr_ready, busy
  );

endinterface

// File: rtl/vga2_fb_ram.sv
// -----------------------------------------------------------------------------
// vga2_fb_ram
// Simple dual-port pixel RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
// Contents are never initialised; there is deliberately no reset.
//   clock      : clock, rising edge
//   i_wr_en    : write enable
//   i_wr_addr  : write address (caller keeps it below Depth)
//   i_wr_data  : write word
//   i_rd_addr  : read address (caller keeps it below Depth)
//   o_rd_data  : read word, valid one cycle after i_rd_addr is sampled
// -----------------------------------------------------------------------------
module vga2_fb_ram #(
  parameter int Depth = 307200,
  parameter int AddrW = 19,
  parameter int DataW = 3
) (
  input  logic             clock,
  input  logic             i_wr_en,
  input  logic [AddrW-1:0] i_wr_addr,
  input  logic [DataW-1:0] i_wr_data,
  input  logic [AddrW-1:0] i_rd_addr,
  output logic [DataW-1:0] o_rd_data
);

  logic [DataW-1:0] r_mem [Depth];

  // Read and write in one block: the read samples the array before the
  // non-blocking write lands, giving read-before-write behaviour.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/vga2_framebuffer.sv
// -----------------------------------------------------------------------------
// vga2_framebuffer
// Pixel store feeding VGA2Interface. The display side reads one pixel per
// clock with fixed latency 1; a drawing client writes pixels through a
// valid/ready handshake; a clear engine fills the whole buffer with one colour.
//   clock                : system clock, rising edge
//   reset                : synchronous, active-low
//   fb_addr_h, fb_addr_v : read column / line from VGA2Interface
//   color_r/g/b          : pixel colour, 000 for out-of-range addresses
//   wr_bus               : client write / clear bus (slave side)
// -----------------------------------------------------------------------------
module vga2_framebuffer
  import vga2_pkg::*;
#(
  parameter int HAddrSize = 11,
  parameter int VAddrSize = 11,
  parameter int Width     = 640,
  parameter int Height    = 480
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [HAddrSize-1:0] fb_addr_h,
  input  logic [VAddrSize-1:0] fb_addr_v,
  output logic                 color_r,
  output logic                 color_g,
  output logic                 color_b,
  vga2_framebuffer_if.slave    wr_bus
);

  localparam int Depth = Width * Height;
  localparam int RamAw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int IdxW  = HAddrSize + VAddrSize;

  localparam logic [HAddrSize-1:0] HLim    = HAddrSize'(Width);
  localparam logic [VAddrSize-1:0] VLim    = VAddrSize'(Height);
  localparam logic [RamAw-1:0]     LastIdx = RamAw'(Depth - 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0]  w_rd_idx;
  logic [IdxW-1:0]  w_wr_idx;
  logic             w_rd_in_range;
  logic             w_wr_in_range;
  logic [RamAw-1:0] w_rd_addr;

  assign w_rd_idx = IdxW'(lin_index(64'(fb_addr_h), 64'(fb_addr_v), 64'(Width)));
  assign w_wr_idx = IdxW'(lin_index(64'(wr_bus.wr_h), 64'(wr_bus.wr_v), 64'(Width)));

  assign w_rd_in_range = (fb_addr_h < HLim) && (fb_addr_v < VLim);
  assign w_wr_in_range = (wr_bus.wr_h < HLim) && (wr_bus.wr_v < VLim);

  // Out-of-range reads are steered to a legal address; their data is masked
  // at the output anyway.
  assign w_rd_addr = w_rd_in_range ? RamAw'(w_rd_idx) : '0;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [RamAw-1:0] r_clr_cnt;
  color_t           r_fill;
  logic             r_busy;
  logic             r_wr_ready;
  logic             r_rd_valid;

  // ---------------------------------------------------------------------------
  // RAM write port mux: the clear engine owns the port in CLEAR, the client
  // owns it in IDLE. Nothing is committed on a reset edge.
  // ---------------------------------------------------------------------------
  logic             w_ram_we;
  logic [RamAw-1:0] w_ram_waddr;
  color_t           w_ram_wdata;
  color_t           w_ram_q;

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = '0;
    w_ram_wdata = COLOR_BLACK;
    if (reset) begin
      if (r_state == ST_CLEAR) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_clr_cnt;
        w_ram_wdata = r_fill;
      end else if (wr_bus.wr_valid && r_wr_ready && w_wr_in_range) begin
        // Out-of-range writes still complete the handshake but never reach
        // the array.
        w_ram_we    = 1'b1;
        w_ram_waddr = RamAw'(w_wr_idx);
        w_ram_wdata = '{r: wr_bus.wr_r, g: wr_bus.wr_g, b: wr_bus.wr_b};
      end
    end
  end

  vga2_fb_ram #(
    .Depth (Depth),
    .AddrW (RamAw),
    .DataW (3)
  ) u_ram (
    .clock     (clock),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (w_ram_waddr),
    .i_wr_data (w_ram_wdata),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  // ---------------------------------------------------------------------------
  // FSM with registered handshake/status outputs. wr_ready is held low on
  // every reset edge and rises on the first edge after reset is released.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_busy     <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_in_range;
      case (r_state)
        ST_IDLE: begin
          if (wr_bus.clr_start) begin
            r_fill     <= '{r: wr_bus.clr_r, g: wr_bus.clr_g, b: wr_bus.clr_b};
            r_clr_cnt  <= '0;
            r_state    <= ST_CLEAR;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end else begin
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clr_start is intentionally not looked at here.
          if (r_clr_cnt == LastIdx) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
            r_clr_cnt  <= '0;
          end else begin
            r_clr_cnt  <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  color_t w_color;

  assign w_color  = r_rd_valid ? w_ram_q : COLOR_BLACK;
  assign color_r  = w_color.r;
  assign color_g  = w_color.g;
  assign color_b  = w_color.b;

  assign wr_bus.wr_ready = r_wr_ready;
  assign wr_bus.busy     = r_busy;

endmodule

// File: doc/vga2_framebuffer.md
Name: vga2_framebuffer

Overview:
- Pixel store upstream of VGA2Interface: serves 3-bit colour (r,g,b) for the fb_addr_h/fb_addr_v address that VGA2Interface emits.
- Dual-ported:
  - read side, driven by the display timing, one pixel per clock;
  - write side, driven by a drawing client through a valid/ready handshake.
- Built-in clear engine fills the whole buffer with one colour.

Parameters:
- HAddrSize, 11, width of horizontal address buses.
- VAddrSize, 11, width of vertical address buses.
- Width, 640, visible pixels per line (must equal VGA2Interface HVisibleArea).
- Height, 480, visible lines (must equal VGA2Interface VVisibleArea).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- fb_addr_h  in  HAddrSize  read column from VGA2Interface.
- fb_addr_v  in  VAddrSize  read line from VGA2Interface.
- color_r / color_g / color_b  out  1 each  pixel colour to VGA2Interface.
- wr_valid  in  1  write request.
- wr_ready  out  1  write side can accept.
- wr_h  in  HAddrSize  write column.
- wr_v  in  VAddrSize  write line.
- wr_r / wr_g / wr_b  in  1 each  write colour.
- clr_start  in  1  one-cycle pulse: begin clear.
- clr_r / clr_g / clr_b  in  1 each  fill colour, sampled with clr_start.
- busy  out  1  clear in progress.

Behaviour:
- Storage:
  - Width*Height words of 3 bits; linear index = v*Width + h.
  - Index arithmetic at HAddrSize+VAddrSize bits; no truncation.
  - Contents are not initialised or altered by reset.
- Read:
  - Fixed latency 1: address sampled at edge N, colour valid after edge N, held until the next edge.
  - Address with h>=Width or v>=Height returns 000 on the following cycle.
  - Reads never stall and are independent of the write/clear state.
- Same-cycle read and write/clear to one index: read returns the old data (read-before-write).
- Reset (reset==0 at an edge):
  - color_* = 000, busy = 0, state = IDLE, clear counter = 0.
  - wr_ready = 0 while reset is low; no write or clear is committed on a reset edge.
  - A clear in progress is aborted; the buffer is left partially filled.
- State machine, IDLE and CLEAR:
  - IDLE: wr_ready = 1, busy = 0.
    - Write commits at any edge with wr_valid && wr_ready.
    - Writes with out-of-range wr_h/wr_v are accepted (handshake completes) and dropped.
    - clr_start: latch fill colour, counter <= 0, go to CLEAR.
    - wr_valid and clr_start in the same IDLE cycle: the write commits, then CLEAR starts next cycle and overwrites it.
  - CLEAR: wr_ready = 0, busy = 1.
    - Each cycle writes fill colour at counter, counter += 1.
    - After writing index Width*Height-1, go to IDLE.
    - busy is high for exactly Width*Height cycles.
    - clr_start is ignored while in CLEAR.
- wr_ready and busy are decoded from the state register only (no combinational path from inputs).

Decomposition:
- Shared package vga2_pkg:
  - colour triple typedef (r,g,b);
  - state encoding (IDLE, CLEAR);
  - COLOR_BLACK constant;
  - helper function for linear index computation.
- One sub-module, vga2_fb_ram:
  - simple dual-port RAM, 3-bit words;
  - synchronous read with read-before-write, one write port;
  - depth Width*Height.
- Top holds the FSM, clear counter, range checks and output muxing.

Test Plan (Width=4, Height=5, HAddrSize=VAddrSize=11, matching the VGA2Interface sim):
1. Reset hold 2 cycles, then release -> color=000, busy=0, wr_ready=0 during reset and 1 on the first cycle after release.
2. clr_start with clr=001 -> busy high exactly 20 cycles, wr_ready=0 throughout. Afterwards, scanning all 20 addresses returns 001, each one cycle after its address.
3. Write (h=2,v=3,rgb=110) then read fb_addr=(2,3) -> color=110 one cycle after the address edge. Reads of (1,3) and (3,3) stay 001.
4. Same-cycle write (0,0)=100 and read (0,0) -> old value 001 that cycle; the next read of (0,0) returns 100.
5. Read (4,0) and (0,5) -> 000. Write to (7,7) -> handshake completes and no stored pixel changes (full scan check).
6. Start clear 111, assert reset after 6 busy cycles -> busy=0 next cycle; indices 0..5 read 111 and indices 6..19 keep prior contents. A subsequent clr_start is accepted.
